// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: sequences MEM-stage loads and stores onto a req/ack data-memory port.
// Optional REQ timeout abort is compiled in with `define LSU_TIMEOUT_EN.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        load_valid,
  output logic        access_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic        req_any, legal, aligned, timed_out, is_load;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, shifted, load_fmt;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("lsu_mem_ctrl: TIMEOUT must be in 2..255");
  end

  assign req_any = rd_en | wr_en;

  // Stores win over loads, so legality and lane steering key off wr_en.
  always_comb begin
    if (wr_en) legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    else       legal = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (func3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    lane_mask  = 4'b0000;
    lane_wdata = wdata;
    if (wr_en) begin
      case (func3[1:0])
        2'b00: begin
          lane_mask  = 4'b0001 << addr[1:0];
          lane_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          lane_mask  = 4'b0011 << addr[1:0];
          lane_wdata = {2{wdata[15:0]}};
        end
        default: lane_mask = 4'b1111;
      endcase
    end
  end

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'd0, shifted[7:0]};
      3'b101:  load_fmt = {16'd0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt;

  // Held at zero outside REQ so every access starts its budget fresh.
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= 8'd0;
    else if (state != REQ)   cnt <= 8'd0;
    else if (!mem_ack)       cnt <= cnt + 8'd1;
  end

  assign timed_out = (cnt == 8'(TIMEOUT - 1)) && !mem_ack;
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    load_valid = 1'b0;
    access_err = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          stall     = 1'b1;
          state_nxt = (legal && aligned) ? REQ : ERR;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack)        state_nxt = DONE;
        else if (timed_out) state_nxt = ERR;
      end
      DONE: begin
        load_valid = is_load;
        state_nxt  = IDLE;
      end
      default: begin
        access_err = 1'b1;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
      rdata     <= 32'd0;
      off       <= 2'd0;
      f3        <= 3'd0;
      is_load   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any && legal && aligned) begin
        mem_we    <= wr_en;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_wdata <= lane_wdata;
        mem_wmask <= lane_mask;
        off       <= addr[1:0];
        f3        <= func3;
        is_load   <= ~wr_en;
      end
      if (state == REQ && mem_ack && is_load) rdata <= load_fmt;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: table of transactions through a scoreboard queue,
// plus hand sequences for reset, stray acks and (with LSU_TIMEOUT_EN) the REQ timeout.
module tb_lsu_mem_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        stall, load_valid, access_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  lsu_mem_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .func3(func3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .load_valid(load_valid), .access_err(access_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          ack_dly;
    logic [31:0] mrdata;
    int          exp_req, exp_stall, exp_lv, exp_err;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwdata;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] last_rd = 32'd0;

  // Bus-side monitor, sampling on the falling edge.
  int          req_cnt, stall_cnt, lv_cnt, err_cnt;
  logic [31:0] obs_addr, obs_wdata, lv_rdata;
  logic [3:0]  obs_mask;
  logic        obs_we, prev_req, unstable;

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (mem_req) begin
      if (prev_req && (mem_addr != obs_addr || mem_wdata != obs_wdata ||
                       mem_wmask != obs_mask || mem_we != obs_we))
        unstable = 1'b1;
      req_cnt++;
      obs_addr  = mem_addr;
      obs_wdata = mem_wdata;
      obs_mask  = mem_wmask;
      obs_we    = mem_we;
    end
    prev_req = mem_req;
    if (load_valid) begin
      lv_cnt++;
      lv_rdata = rdata;
    end
    if (access_err) err_cnt++;
  end

  task automatic clearMon();
    req_cnt = 0; stall_cnt = 0; lv_cnt = 0; err_cnt = 0;
    unstable = 1'b0; prev_req = 1'b0;
    obs_addr = 32'd0; obs_wdata = 32'd0; obs_mask = 4'd0; obs_we = 1'b0;
    lv_rdata = 32'd0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int dly,
                              input logic [31:0] mrd, input int ereq, input int estall,
                              input int elv, input int eerr, input logic [31:0] emaddr,
                              input logic [3:0] emask, input logic [31:0] emwd,
                              input logic ewe, input logic [31:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.ack_dly = dly;
    v.mrdata = mrd; v.exp_req = ereq; v.exp_stall = estall; v.exp_lv = elv;
    v.exp_err = eerr; v.exp_maddr = emaddr; v.exp_mask = emask; v.exp_mwdata = emwd;
    v.exp_we = ewe; v.exp_rdata = erd;
    return v;
  endfunction

  // Drives one MEM-stage access and plays the memory side; ack_dly 0 means never ack.
  task automatic applyStimulus(input vec_t v);
    sb.push_back(v);
    @(posedge clk); #1;
    clearMon();
    rd_en = v.rd; wr_en = v.wr; func3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    if (v.ack_dly > 0) begin
      repeat (v.ack_dly - 1) begin
        @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = v.mrdata;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      repeat (3) @(posedge clk);
    end else begin
      repeat (10) @(posedge clk);
    end
    #1;
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkVal("req_cycles", 32'(req_cnt), 32'(e.exp_req));
    checkVal("stall_cycles", 32'(stall_cnt), 32'(e.exp_stall));
    checkVal("load_valid_pulses", 32'(lv_cnt), 32'(e.exp_lv));
    checkVal("access_err_pulses", 32'(err_cnt), 32'(e.exp_err));
    if (e.exp_req > 0) begin
      checkVal("mem_addr", obs_addr, e.exp_maddr);
      checkVal("mem_wmask", {28'd0, obs_mask}, {28'd0, e.exp_mask});
      checkVal("mem_we", {31'd0, obs_we}, {31'd0, e.exp_we});
      checkVal("req_stable", {31'd0, unstable}, 32'd0);
      if (e.exp_we) checkVal("mem_wdata", obs_wdata, e.exp_mwdata);
    end
    if (e.exp_lv > 0) begin
      checkVal("load_rdata", lv_rdata, e.exp_rdata);
      last_rd = e.exp_rdata;
    end
    checkVal("rdata_hold", rdata, last_rd);
    checkVal("idle_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rd wr f3 addr wdata dly mem_rdata | req stall lv err maddr mask mwdata we rdata
    vecs.push_back(mk(0,1,3'b010,32'h100,32'hDEADBEEF,2,32'h0,        2,3,0,0,32'h100,4'b1111,32'hDEADBEEF,1,32'h0));
    vecs.push_back(mk(1,0,3'b000,32'h203,32'h0,       1,32'h80FF7F01, 1,2,1,0,32'h200,4'b0000,32'h0,0,32'hFFFFFF80));
    vecs.push_back(mk(1,0,3'b100,32'h203,32'h0,       3,32'h80FF7F01, 3,4,1,0,32'h200,4'b0000,32'h0,0,32'h00000080));
    vecs.push_back(mk(0,1,3'b001,32'h102,32'h1234ABCD,1,32'h0,        1,2,0,0,32'h100,4'b1100,32'hABCDABCD,1,32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h101,32'h0,       0,32'h0,        0,1,0,1,32'h0,4'b0000,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b011,32'h100,32'h0,       0,32'h0,        0,1,0,1,32'h0,4'b0000,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b001,32'h202,32'h0,       2,32'h80FF7F01, 2,3,1,0,32'h200,4'b0000,32'h0,0,32'hFFFF80FF));
    vecs.push_back(mk(1,0,3'b101,32'h200,32'h0,       1,32'h1234F00D, 1,2,1,0,32'h200,4'b0000,32'h0,0,32'h0000F00D));
    vecs.push_back(mk(0,1,3'b000,32'h101,32'h000000A5,1,32'h0,        1,2,0,0,32'h100,4'b0010,32'hA5A5A5A5,1,32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h300,32'h0,       2,32'hCAFEBABE, 2,3,1,0,32'h300,4'b0000,32'h0,0,32'hCAFEBABE));
    vecs.push_back(mk(0,1,3'b001,32'h103,32'h0,       0,32'h0,        0,1,0,1,32'h0,4'b0000,32'h0,0,32'h0));
    vecs.push_back(mk(0,1,3'b100,32'h100,32'h0,       0,32'h0,        0,1,0,1,32'h0,4'b0000,32'h0,0,32'h0));
    vecs.push_back(mk(1,1,3'b010,32'h013,32'h11223344,1,32'h0,        0,1,0,1,32'h0,4'b0000,32'h0,0,32'h0));
    vecs.push_back(mk(1,1,3'b010,32'h010,32'h11223344,1,32'h0,        1,2,0,0,32'h010,4'b1111,32'h11223344,1,32'h0));
    vecs.push_back(mk(1,0,3'b000,32'h201,32'h0,       1,32'h80FF7F01, 1,2,1,0,32'h200,4'b0000,32'h0,0,32'h0000007F));
    vecs.push_back(mk(0,1,3'b000,32'h103,32'h0000005A,2,32'h0,        2,3,0,0,32'h100,4'b1000,32'h5A5A5A5A,1,32'h0));
    vecs.push_back(mk(1,0,3'b001,32'h201,32'h0,       0,32'h0,        0,1,0,1,32'h0,4'b0000,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b101,32'h202,32'h0,       1,32'h80FF7F01, 1,2,1,0,32'h200,4'b0000,32'h0,0,32'h000080FF));
`ifdef LSU_TIMEOUT_EN
    vecs.push_back(mk(1,0,3'b010,32'h500,32'h0,       0,32'h0,        4,5,0,1,32'h500,4'b0000,32'h0,0,32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h504,32'h0,       4,32'h0BADF00D, 4,5,1,0,32'h504,4'b0000,32'h0,0,32'h0BADF00D));
`endif

    clearMon();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkVal("reset_mem_req", {31'd0, mem_req}, 32'd0);
    checkVal("reset_stall", {31'd0, stall}, 32'd0);
    checkVal("reset_load_valid", {31'd0, load_valid}, 32'd0);
    checkVal("reset_access_err", {31'd0, access_err}, 32'd0);
    checkVal("reset_mem_we", {31'd0, mem_we}, 32'd0);
    checkVal("reset_mem_addr", mem_addr, 32'd0);
    checkVal("reset_mem_wdata", mem_wdata, 32'd0);
    checkVal("reset_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    checkVal("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // A stray ack while idle must not start or finish anything.
    clearMon();
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("stray_ack_req", 32'(req_cnt), 32'd0);
    checkVal("stray_ack_lv", 32'(lv_cnt + err_cnt + stall_cnt), 32'd0);
    checkVal("stray_ack_rdata", rdata, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Reset in REQ abandons the access; the late ack that follows is ignored.
    @(posedge clk); #1;
    clearMon();
    rd_en = 1'b1; func3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    rd_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_in_req_req_cycles", 32'(req_cnt), 32'd1);
    checkVal("rst_in_req_lv", 32'(lv_cnt), 32'd0);
    checkVal("rst_in_req_err", 32'(err_cnt), 32'd0);
    checkVal("rst_in_req_mem_req", {31'd0, mem_req}, 32'd0);
    checkVal("rst_in_req_stall", {31'd0, stall}, 32'd0);
    checkVal("rst_in_req_rdata", rdata, 32'd0);
    last_rd = 32'd0;

    // The unit is usable again after the abandoned access.
    applyStimulus(mk(1,0,3'b100,32'h402,32'h0,1,32'h00C30000,1,2,1,0,32'h400,4'b0000,32'h0,0,32'h000000C3));
    checkOutput();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequences MEM-stage loads and stores from the pipelined core onto a variable-latency data-memory port using a req/ack handshake.
- Consumes the decoder's data_mem_rd_en / data_mem_wr_en and the instruction's func3. Handles byte-lane alignment, write masks and load sign/zero extension.
- Stalls the pipeline until each access completes.
- Sits between the EX/MEM pipeline register and data memory; its result feeds writeback select 01.

Parameters:
- TIMEOUT, 16: max REQ cycles without mem_ack before abort. Used only with LSU_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  load request (data_mem_rd_en from MEM stage)
- wr_en  in  1  store request (data_mem_wr_en from MEM stage)
- func3  in  3  instr[14:12] of the MEM-stage instruction
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  hold IF..MEM pipeline registers
- rdata  out  32  formatted load result
- load_valid  out  1  rdata valid this cycle (one-cycle pulse)
- access_err  out  1  misaligned/illegal/timeout pulse
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  4  byte-lane write enables
- mem_ack  in  1  bus completion, one-cycle pulse
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- States: IDLE, REQ, DONE, ERR.
- Reset values: state = IDLE. mem_req, mem_we, load_valid and access_err = 0. mem_addr, mem_wdata, mem_wmask and rdata = 0.
- Request priority: wr_en has priority; if rd_en and wr_en are both 1, the access is a store and rd_en is ignored.
- stall (combinational): 1 in REQ; 1 in IDLE when (rd_en|wr_en); 0 in DONE and ERR.
- IDLE with a request and a legal, aligned access:
  - Register mem_addr, mem_we, mem_wdata, mem_wmask and the byte offset.
  - Go to REQ; mem_req = 1 from the next cycle.
- Legal func3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other func3 is illegal.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
- Illegal or misaligned in IDLE: go to ERR, no bus access.
- Store lanes (off = addr[1:0]):
  - SB: mask = 4'b0001 << off; wdata = {4{wdata[7:0]}}.
  - SH: mask = 4'b0011 << off; wdata = {2{wdata[15:0]}}.
  - SW: mask = 4'b1111; wdata unchanged.
  - Loads drive mask = 0.
- REQ:
  - mem_req, mem_addr, mem_we, mem_wdata and mem_wmask are held stable until mem_ack is sampled 1.
  - On mem_ack: mem_req = 0 next cycle; go to DONE.
  - For loads, rdata is captured from mem_rdata >> (8*off), then sign- or zero-extended per func3.
- DONE (1 cycle): load_valid = 1 for loads only; stall = 0 so the instruction advances; MEM-stage inputs are ignored; go to IDLE.
- ERR (1 cycle): access_err = 1; stall = 0; no writeback data; go to IDLE.
- Latency: request seen in cycle T, mem_ack in cycle A (A >= T+1) gives DONE in A+1. Minimum 3 cycles, stall high for 2.
- rdata holds its last value outside DONE.
- mem_ack outside REQ is ignored.
- Back-to-back accesses: the next instruction is first seen in the IDLE cycle after DONE or ERR.
- rst in any state: IDLE next cycle, mem_req dropped, outstanding access abandoned. A late mem_ack after reset is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When the count reaches TIMEOUT-1 with no ack, mem_req drops next cycle and the state goes to ERR (access_err pulse).
  - mem_ack arriving in the same cycle as the limit wins: normal DONE.
- Not defined: REQ waits indefinitely; no counter logic is present.

Test Plan:
1. Aligned SW: addr = 0x100, wdata = 0xDEADBEEF, ack 2 cycles later -> mem_req held 2 cycles, mem_addr = 0x100, mask = 1111, stall high 3 cycles, no load_valid.
2. LB / LBU: mem_rdata = 0x80FF7F01 at addr 0x203 -> LB gives rdata = 0xFFFFFF80 with a load_valid pulse; LBU gives 0x00000080.
3. SH at addr 0x102 with wdata = 0x1234ABCD -> mem_addr = 0x100, mask = 1100, mem_wdata = 0xABCDABCD.
4. LW at addr 0x101 -> no mem_req; ERR with access_err = 1 for one cycle; stall high exactly 1 cycle. func3 = 011 load -> same response.
5. rst asserted in REQ, then mem_ack one cycle later -> IDLE, mem_req = 0, no load_valid, ack ignored.
6. With LSU_TIMEOUT_EN and TIMEOUT = 4, no ack -> mem_req high 4 cycles, then access_err pulse. With ack on the 4th cycle -> DONE, no error.
